sonar_echo_responder: RTL

//   Synthesizable ultrasonic sensor emulator; the sensor end of the trigger/echo ranging link.

---
 rtl/sonar_pkg.sv | 33 +++
 rtl/sonar_echo_responder_if.sv | 26 ++
 rtl/trig_sync_edge.sv | 26 ++
 rtl/sonar_echo_responder.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/sonar_pkg.sv
// Shared types and default 50 MHz timing for the sonar trigger/echo link.
// The ranging-side converter uses the same cycles-per-cm derivation.
package sonar_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StTrigHi,
        StBurst,
        StEcho,
        StHoldoff
    } sonar_state_e;

    localparam int unsigned CLK_HZ    = 50_000_000;
    localparam int unsigned SOUND_MPS = 343;

    // Round-trip cycles per cm: 2 * 0.01 m / speed of sound, rounded to nearest.
    function automatic int unsigned cyc_per_cm_calc(int unsigned clk_hz, int unsigned sound_mps);
        return (2 * clk_hz + 50 * sound_mps) / (100 * sound_mps);
    endfunction

    function automatic int unsigned max2(int unsigned a, int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned DEF_DIST_W          = 9;
    localparam int unsigned DEF_TRIG_MIN_CYC    = 500;
    localparam int unsigned DEF_BURST_DELAY_CYC = 10_000;
    localparam int unsigned DEF_CYC_PER_CM      = cyc_per_cm_calc(CLK_HZ, SOUND_MPS);
    localparam int unsigned DEF_MAX_CM          = 400;
    localparam int unsigned DEF_TIMEOUT_CYC     = 1_900_000;
    localparam int unsigned DEF_HOLDOFF_CYC     = 500_000;

endpackage

// File: rtl/sonar_echo_responder_if.sv
// Trigger/echo link between a ranging controller (master) and the sensor (slave).
interface sonar_echo_responder_if #(
    parameter int unsigned DIST_W = 9
) ();
    logic              trigger;
    logic [DIST_W-1:0] distance_cm;
    logic              echo;
    logic              busy;
    logic              short_trig;

    modport master (
        output trigger,
        output distance_cm,
        input  echo,
        input  busy,
        input  short_trig
    );

    modport slave (
        input  trigger,
        input  distance_cm,
        output echo,
        output busy,
        output short_trig
    );
endinterface

// File: rtl/trig_sync_edge.sv
// Two-flop synchronizer for the asynchronous trigger plus edge detection.
// A level first sampled at edge k produces a rise/fall pulse consumed at edge k+2.
module trig_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic rise,
    output logic fall
);
    logic meta_q, sync_q, prev_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;
endmodule

// File: rtl/sonar_echo_responder.sv
// Ultrasonic sensor emulator: validates the trigger width, waits the burst delay, then
// holds echo high for the round-trip time of the latched distance, followed by a dead time.
module sonar_echo_responder
    import sonar_pkg::*;
#(
    parameter int unsigned DIST_W          = DEF_DIST_W,
    parameter int unsigned TRIG_MIN_CYC    = DEF_TRIG_MIN_CYC,
    parameter int unsigned BURST_DELAY_CYC = DEF_BURST_DELAY_CYC,
    parameter int unsigned CYC_PER_CM      = DEF_CYC_PER_CM,
    parameter int unsigned MAX_CM          = DEF_MAX_CM,
    parameter int unsigned TIMEOUT_CYC     = DEF_TIMEOUT_CYC,
    parameter int unsigned HOLDOFF_CYC     = DEF_HOLDOFF_CYC
) (
    input logic                   clock,
    input logic                   reset,
    sonar_echo_responder_if.slave bus
);
    localparam int unsigned CNT_MAX = max2(max2(TRIG_MIN_CYC, BURST_DELAY_CYC),
                                           max2(TIMEOUT_CYC, HOLDOFF_CYC));
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned SUB_W   = (CYC_PER_CM > 1) ? $clog2(CYC_PER_CM) : 1;

    sonar_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SUB_W-1:0]  sub_q, sub_d;
    logic [DIST_W-1:0] cm_q, cm_d;
    logic [DIST_W-1:0] dist_q, dist_d;
    logic              timeout_q, timeout_d;
    logic              echo_q, echo_d;
    logic              short_q, short_d;
    logic              trig_rise, trig_fall;
    logic              sub_last, echo_done;

    trig_sync_edge u_trig_sync_edge (
        .clock    (clock),
        .reset    (reset),
        .async_in (bus.trigger),
        .rise     (trig_rise),
        .fall     (trig_fall)
    );

    assign sub_last  = (sub_q == SUB_W'(CYC_PER_CM - 1));
    // Echo width is cm_count * CYC_PER_CM built from two counters instead of a multiply.
    assign echo_done = timeout_q ? (cnt_q == CNT_W'(TIMEOUT_CYC - 1))
                                 : (sub_last && (cm_q == dist_q - DIST_W'(1)));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sub_d     = sub_q;
        cm_d      = cm_q;
        dist_d    = dist_q;
        timeout_d = timeout_q;
        echo_d    = echo_q;
        short_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (trig_rise) begin
                    state_d = StTrigHi;
                    cnt_d   = CNT_W'(1);
                end
            end
            StTrigHi: begin
                if (trig_fall) begin
                    cnt_d = '0;
                    if (cnt_q >= CNT_W'(TRIG_MIN_CYC)) begin
                        state_d   = StBurst;
                        dist_d    = bus.distance_cm;
                        timeout_d = (bus.distance_cm == '0) ||
                                    (bus.distance_cm > DIST_W'(MAX_CM));
                    end else begin
                        state_d = StIdle;
                        short_d = 1'b1;
                    end
                end else if (cnt_q < CNT_W'(TRIG_MIN_CYC)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StBurst: begin
                if (cnt_q == CNT_W'(BURST_DELAY_CYC - 1)) begin
                    state_d = StEcho;
                    echo_d  = 1'b1;
                    cnt_d   = '0;
                    sub_d   = '0;
                    cm_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StEcho: begin
                if (echo_done) begin
                    state_d = StHoldoff;
                    echo_d  = 1'b0;
                    cnt_d   = '0;
                end else if (timeout_q) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (sub_last) begin
                    sub_d = '0;
                    cm_d  = cm_q + DIST_W'(1);
                end else begin
                    sub_d = sub_q + SUB_W'(1);
                end
            end
            StHoldoff: begin
                if (cnt_q == CNT_W'(HOLDOFF_CYC - 1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            sub_q     <= '0;
            cm_q      <= '0;
            dist_q    <= '0;
            timeout_q <= 1'b0;
            echo_q    <= 1'b0;
            short_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sub_q     <= sub_d;
            cm_q      <= cm_d;
            dist_q    <= dist_d;
            timeout_q <= timeout_d;
            echo_q    <= echo_d;
            short_q   <= short_d;
        end
    end

    assign bus.echo       = echo_q;
    assign bus.short_trig = short_q;
    assign bus.busy       = (state_q == StBurst) || (state_q == StEcho) || (state_q == StHoldoff);
endmodule
